// File: rtl/accum_unit.sv
// accum_unit: accumulator with direct add/sub/load/clear and a counted burst-accumulate FSM
// Ports: CLK clock, Clrn async active-low reset, A operand, Add/Sub/Load/Clr direct ops (IDLE only),
//        Start/Len burst request, In_valid/In_ready burst sample handshake,
//        B accumulator, Ovf sticky overflow, Busy not-idle, Done burst-complete pulse
module accum_unit #(
  parameter int WIDTH    = 8,
  parameter int CNT_W    = 4,
  parameter int SATURATE = 1
) (
  input  logic             CLK,
  input  logic             Clrn,
  input  logic [WIDTH-1:0] A,
  input  logic             Add,
  input  logic             Sub,
  input  logic             Load,
  input  logic             Clr,
  input  logic             Start,
  input  logic [CNT_W-1:0] Len,
  input  logic             In_valid,
  output logic             In_ready,
  output logic [WIDTH-1:0] B,
  output logic             Ovf,
  output logic             Busy,
  output logic             Done
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t state, nxt;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] b_n, add_res, sub_res;
  logic o_n;
  logic [WIDTH:0] sum, dif;
  assign sum = {1'b0, B} + {1'b0, A};
  assign dif = {1'b0, B} - {1'b0, A};
  assign add_res = (SATURATE != 0 && sum[WIDTH]) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
  assign sub_res = (SATURATE != 0 && dif[WIDTH]) ? '0 : dif[WIDTH-1:0];
  assign Busy = state != IDLE;
  assign In_ready = state == ACCUM;
  assign Done = state == DONE;
  always_ff @(posedge CLK or negedge Clrn)
    if (!Clrn) begin
      state <= IDLE;
      B <= '0;
      Ovf <= 1'b0;
      cnt <= '0;
    end else begin
      state <= nxt;
      B <= b_n;
      Ovf <= o_n;
      cnt <= cnt_n;
    end
  always_comb begin
    nxt = state;
    b_n = B;
    o_n = Ovf;
    cnt_n = cnt;
    case (state)
      IDLE:
        if (Start) begin
          b_n = '0;
          o_n = 1'b0;
          cnt_n = Len;
          nxt = (Len == '0) ? DONE : ACCUM;
        end else if (Clr) begin
          b_n = '0;
          o_n = 1'b0;
        end else if (Add) begin
          b_n = add_res;
          o_n = Ovf | sum[WIDTH];
        end else if (Sub) begin
          b_n = sub_res;
          o_n = Ovf | dif[WIDTH];
        end else if (Load) begin
          b_n = A;
          o_n = 1'b0;
        end
      ACCUM:
        if (In_valid) begin
          b_n = add_res;
          o_n = Ovf | sum[WIDTH];
          cnt_n = cnt - 1'b1;
          nxt = (cnt == CNT_W'(1)) ? DONE : ACCUM;
        end
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_accum_unit.sv
// tb_accum_unit: vector table and scoreboard check of saturating and wrapping accum_unit instances
module tb_accum_unit;
  typedef struct {
    logic [5:0] ctl;
    logic [7:0] a;
    logic [3:0] len;
    logic [7:0] b;
    logic [7:0] bw;
    logic [1:0] ov;
    logic [2:0] fl;
  } vec_t;
  logic CLK = 1'b0;
  logic Clrn = 1'b0;
  logic Add, Sub, Load, Clr, Start, In_valid;
  logic [7:0] A;
  logic [3:0] Len;
  logic [7:0] B, Bw;
  logic Ovf, Ovfw, Busy, Busyw, In_ready, In_readyw, Done, Donew;
  int checks = 0;
  int errors = 0;
  vec_t tbl[27];
  vec_t sb[$];
  always #5 CLK = ~CLK;
  accum_unit #(.WIDTH(8), .CNT_W(4), .SATURATE(1)) dut (
    .CLK(CLK), .Clrn(Clrn), .A(A), .Add(Add), .Sub(Sub), .Load(Load), .Clr(Clr),
    .Start(Start), .Len(Len), .In_valid(In_valid), .In_ready(In_ready),
    .B(B), .Ovf(Ovf), .Busy(Busy), .Done(Done)
  );
  accum_unit #(.WIDTH(8), .CNT_W(4), .SATURATE(0)) dutw (
    .CLK(CLK), .Clrn(Clrn), .A(A), .Add(Add), .Sub(Sub), .Load(Load), .Clr(Clr),
    .Start(Start), .Len(Len), .In_valid(In_valid), .In_ready(In_readyw),
    .B(Bw), .Ovf(Ovfw), .Busy(Busyw), .Done(Donew)
  );
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  task automatic compare(input string n, input vec_t e);
    chk({n, ".B"}, int'(B), int'(e.b));
    chk({n, ".Bw"}, int'(Bw), int'(e.bw));
    chk({n, ".Ovf"}, int'(Ovf), int'(e.ov[1]));
    chk({n, ".Ovfw"}, int'(Ovfw), int'(e.ov[0]));
    chk({n, ".flags"}, int'({Busy, In_ready, Done}), int'(e.fl));
    chk({n, ".flagsw"}, int'({Busyw, In_readyw, Donew}), int'(e.fl));
  endtask
  task automatic rst_chk(input string n);
    vec_t z;
    z = '{6'b0, 8'd0, 4'd0, 8'd0, 8'd0, 2'b00, 3'b000};
    compare(n, z);
  endtask
  task automatic step(input string n, input vec_t v);
    vec_t e;
    {Start, Clr, Add, Sub, Load, In_valid} = v.ctl;
    A = v.a;
    Len = v.len;
    sb.push_back(v);
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    compare(n, e);
  endtask
  function automatic vec_t v(input logic [5:0] ctl, input logic [7:0] a, input logic [3:0] len,
                             input logic [7:0] b, input logic [7:0] bw, input logic [1:0] ov,
                             input logic [2:0] fl);
    vec_t r;
    r = '{ctl, a, len, b, bw, ov, fl};
    return r;
  endfunction
  initial begin
    tbl[0]  = v(6'b000010, 8'd200, 4'd0, 8'd200, 8'd200, 2'b00, 3'b000);
    tbl[1]  = v(6'b001000, 8'd100, 4'd0, 8'd255, 8'd44,  2'b11, 3'b000);
    tbl[2]  = v(6'b000100, 8'd5,   4'd0, 8'd250, 8'd39,  2'b11, 3'b000);
    tbl[3]  = v(6'b000000, 8'd9,   4'd0, 8'd250, 8'd39,  2'b11, 3'b000);
    tbl[4]  = v(6'b010000, 8'd9,   4'd0, 8'd0,   8'd0,   2'b00, 3'b000);
    tbl[5]  = v(6'b000100, 8'd1,   4'd0, 8'd0,   8'd255, 2'b11, 3'b000);
    tbl[6]  = v(6'b000010, 8'd7,   4'd0, 8'd7,   8'd7,   2'b00, 3'b000);
    tbl[7]  = v(6'b001100, 8'd3,   4'd0, 8'd10,  8'd10,  2'b00, 3'b000);
    tbl[8]  = v(6'b000110, 8'd4,   4'd0, 8'd6,   8'd6,   2'b00, 3'b000);
    tbl[9]  = v(6'b011000, 8'd50,  4'd0, 8'd0,   8'd0,   2'b00, 3'b000);
    tbl[10] = v(6'b001000, 8'd50,  4'd0, 8'd50,  8'd50,  2'b00, 3'b000);
    tbl[11] = v(6'b101000, 8'd9,   4'd3, 8'd0,   8'd0,   2'b00, 3'b110);
    tbl[12] = v(6'b000001, 8'd10,  4'd0, 8'd10,  8'd10,  2'b00, 3'b110);
    tbl[13] = v(6'b001000, 8'd77,  4'd0, 8'd10,  8'd10,  2'b00, 3'b110);
    tbl[14] = v(6'b000001, 8'd20,  4'd0, 8'd30,  8'd30,  2'b00, 3'b110);
    tbl[15] = v(6'b000001, 8'd30,  4'd0, 8'd60,  8'd60,  2'b00, 3'b101);
    tbl[16] = v(6'b000010, 8'd5,   4'd0, 8'd60,  8'd60,  2'b00, 3'b000);
    tbl[17] = v(6'b100000, 8'd5,   4'd0, 8'd0,   8'd0,   2'b00, 3'b101);
    tbl[18] = v(6'b000000, 8'd5,   4'd0, 8'd0,   8'd0,   2'b00, 3'b000);
    tbl[19] = v(6'b100000, 8'd0,   4'd2, 8'd0,   8'd0,   2'b00, 3'b110);
    tbl[20] = v(6'b000001, 8'd200, 4'd0, 8'd200, 8'd200, 2'b00, 3'b110);
    tbl[21] = v(6'b000001, 8'd100, 4'd0, 8'd255, 8'd44,  2'b11, 3'b101);
    tbl[22] = v(6'b000000, 8'd0,   4'd0, 8'd255, 8'd44,  2'b11, 3'b000);
    tbl[23] = v(6'b100000, 8'd0,   4'd1, 8'd0,   8'd0,   2'b00, 3'b110);
    tbl[24] = v(6'b010000, 8'd0,   4'd0, 8'd0,   8'd0,   2'b00, 3'b110);
    tbl[25] = v(6'b000001, 8'd4,   4'd0, 8'd4,   8'd4,   2'b00, 3'b101);
    tbl[26] = v(6'b000000, 8'd0,   4'd0, 8'd4,   8'd4,   2'b00, 3'b000);
    {Start, Clr, Add, Sub, Load, In_valid} = 6'b0;
    A = 8'd0;
    Len = 4'd0;
    #1 rst_chk("por");
    repeat (2) @(posedge CLK);
    #1 rst_chk("por_clk");
    @(negedge CLK);
    Clrn = 1'b1;
    #1 rst_chk("release");
    for (int i = 0; i < 27; i++) step($sformatf("v%0d", i), tbl[i]);
    step("ab_start", v(6'b100000, 8'd0, 4'd4, 8'd0, 8'd0, 2'b00, 3'b110));
    step("ab_s1",    v(6'b000001, 8'd1, 4'd0, 8'd1, 8'd1, 2'b00, 3'b110));
    step("ab_s2",    v(6'b000001, 8'd2, 4'd0, 8'd3, 8'd3, 2'b00, 3'b110));
    {Start, Clr, Add, Sub, Load, In_valid} = 6'b000001;
    A = 8'd3;
    #2 Clrn = 1'b0;
    #1 rst_chk("abort_async");
    @(posedge CLK);
    #1 rst_chk("abort_hold");
    @(negedge CLK);
    Clrn = 1'b1;
    #1 rst_chk("abort_release");
    for (int i = 0; i < 3; i++)
      step($sformatf("post_idle%0d", i), v(6'b000001, 8'd3, 4'd0, 8'd0, 8'd0, 2'b00, 3'b000));
    step("r_start", v(6'b100000, 8'd0, 4'd1, 8'd0, 8'd0, 2'b00, 3'b110));
    step("r_s1",    v(6'b000001, 8'd7, 4'd0, 8'd7, 8'd7, 2'b00, 3'b101));
    step("r_idle",  v(6'b000000, 8'd0, 4'd0, 8'd7, 8'd7, 2'b00, 3'b000));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/accum_unit.md
ACCUM_UNIT -- requirements
Module: accum_unit

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, data and accumulator width in bits (>=2).
REQ-002 SHALL provide parameter CNT_W, default 4, burst-length counter width in bits (>=1).
REQ-003 SHALL provide parameter SATURATE, default 1; 1 = clamp on overflow/underflow, 0 = modulo-2^WIDTH wrap.
REQ-004 CLK  input  1  single clock; all state changes on rising edge.
REQ-005 Clrn  input  1  reset; asynchronous, active-low.
REQ-006 A  input  WIDTH  unsigned data operand.
REQ-007 Add  input  1  direct mode: B <= B + A.
REQ-008 Sub  input  1  direct mode: B <= B - A.
REQ-009 Load  input  1  direct mode: B <= A.
REQ-010 Clr  input  1  direct mode: synchronous clear of B and Ovf.
REQ-011 Start  input  1  begin burst accumulation of Len samples.
REQ-012 Len  input  CNT_W  burst length, sampled only with accepted Start.
REQ-013 In_valid  input  1  burst sample A valid this cycle.
REQ-014 In_ready  output  1  high while the block accepts burst samples.
REQ-015 B  output  WIDTH  accumulator value, registered.
REQ-016 Ovf  output  1  sticky overflow/underflow flag, registered.
REQ-017 Busy  output  1  high in any state other than IDLE.
REQ-018 Done  output  1  one-cycle pulse on burst completion.

Function
REQ-019 FSM SHALL have states IDLE, ACCUM, DONE; Busy = (state != IDLE); In_ready = (state == ACCUM).
REQ-020 In IDLE, SHALL apply exactly one action per cycle, priority Start > Clr > Add > Sub > Load; with none asserted, B and Ovf SHALL hold.
REQ-021 Start in IDLE with Len != 0: B <= 0, Ovf <= 0, counter <= Len, next state ACCUM.
REQ-022 Start in IDLE with Len == 0: B <= 0, Ovf <= 0, next state DONE (empty burst).
REQ-023 In ACCUM, each cycle with In_valid = 1: B <= B + A (per REQ-026), counter decrements; In_valid = 0 cycles SHALL leave B and counter unchanged.
REQ-024 When a sample is accepted with counter == 1, next state SHALL be DONE; DONE lasts exactly one cycle with Done = 1, then IDLE.
REQ-025 Add, Sub, Load, Clr, Start SHALL be ignored outside IDLE; B SHALL hold during DONE.
REQ-026 Arithmetic unsigned at WIDTH+1 bits; carry out of add or borrow from sub SHALL set Ovf; SATURATE = 1 result clamps to 2^WIDTH-1 (add) or 0 (sub); SATURATE = 0 result is the low WIDTH bits.
REQ-027 Ovf SHALL be sticky: set per REQ-026, cleared only by Clr, Load, accepted Start, or reset.
REQ-028 Load SHALL clear Ovf; Clr SHALL set B = 0 and Ovf = 0.
REQ-029 Done SHALL be registered (asserted in the DONE-state cycle), never combinational from inputs.

Reset
REQ-030 Clrn = 0 SHALL immediately force state IDLE, B = 0, Ovf = 0, Done = 0, counter = 0, irrespective of CLK.
REQ-031 Reset asserted mid-burst SHALL abort the burst with no Done pulse; after release the block is in IDLE.
REQ-032 Outputs SHALL remain at reset values until the first rising CLK edge after Clrn deasserts.

Verification
REQ-033 WIDTH=8, SATURATE=1: Load A=200, then Add A=100 -> B=255, Ovf=1; then Sub A=5 -> B=250, Ovf=1 (sticky).
REQ-034 WIDTH=8, SATURATE=0: Load A=200, Add A=100 -> B=44, Ovf=1; Clr -> B=0, Ovf=0.
REQ-035 Start Len=3, samples 10, (In_valid=0 gap), 20, 30 -> In_ready high 4 cycles, B=60, Done pulses once, Busy then low.
REQ-036 Start Len=0 -> Done one cycle later, B=0, no In_ready cycle.
REQ-037 Start and Add asserted together in IDLE -> burst starts, B=0, Add ignored; Add during ACCUM ignored.
REQ-038 Clrn pulsed low after 2 of 4 burst samples -> B=0, Busy=0, no Done; subsequent Start Len=1, A=7 -> B=7, Done pulse.
